// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage valid/ready pipeline around the Hack ALU.
// Stage 1 applies the zx/nx/zy/ny presets, and stage 2 applies f/no
// and derives zr/ng. ops_count counts the output transfers that complete.
module hack_alu_pipe #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [5:0]   ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         zr,
  output logic         ng,
  output logic [15:0]  ops_count
);

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] x1_q, x1_d;
  logic [N-1:0] y1_q, y1_d;
  logic         f1_q, f1_d;
  logic         no1_q, no1_d;
  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] out_q, out_d;
  logic         zr_q, zr_d;
  logic         ng_q, ng_d;
  logic [15:0]  ops_count_q, ops_count_d;

  logic         s1_adv, s2_adv;
  logic [N-1:0] x_zero, y_zero, x_pre, y_pre;
  logic [N-1:0] r, res;

  // Advance conditions and the combinational ready back to upstream
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = rst_n && s1_adv;
  end

  // Stage 1: preset the operands; data is only captured on an input transfer
  always_comb begin
    x_zero     = ctrl[5] ? '0 : x;
    x_pre      = ctrl[4] ? ~x_zero : x_zero;
    y_zero     = ctrl[3] ? '0 : y;
    y_pre      = ctrl[2] ? ~y_zero : y_zero;
    s1_valid_d = s1_valid_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    f1_d       = f1_q;
    no1_d      = no1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        x1_d  = x_pre;
        y1_d  = y_pre;
        f1_d  = ctrl[1];
        no1_d = ctrl[0];
      end
    end
  end

  // Stage 2: function select and output negate; results only change when a valid op moves in
  always_comb begin
    r          = f1_q ? (x1_q + y1_q) : (x1_q & y1_q);
    res        = no1_q ? ~r : r;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res;
        zr_d  = (res == '0);
        ng_d  = res[N-1];
      end
    end
  end

  // Completed-transfer counter, wraps naturally
  always_comb begin
    ops_count_d = ops_count_q;
    if (s2_valid_q && out_ready) ops_count_d = ops_count_q + 16'd1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      f1_q        <= 1'b0;
      no1_q       <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      ops_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      f1_q        <= f1_d;
      no1_q       <= no1_d;
      s2_valid_q  <= s2_valid_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign ops_count = ops_count_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed testbench for hack_alu_pipe with hand-computed expected values.
module tb_hack_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_o;
  logic        zr, ng;
  logic [15:0] ops_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [15:0] exp_ops;

  hack_alu_pipe #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out_o), .zr(zr), .ng(ng), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; x = 16'd5; y = 16'd0; ctrl = 6'b000000; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_o !== 16'd0) begin n_fail++; $display("FAIL reset_out got=%h exp=0000", out_o); end
      n_cmp++; if (zr !== 1'b0 || ng !== 1'b0) begin n_fail++; $display("FAIL reset_flags got zr=%b ng=%b exp 0 0", zr, ng); end
      n_cmp++; if (ops_count !== 16'd0) begin n_fail++; $display("FAIL reset_ops got=%0d exp=0", ops_count); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=0", out_valid); end
    exp_ops = 16'd0;
  endtask

  // One operation through an empty pipe with out_ready high
  task automatic single_op(input string nm, input logic [15:0] xv, input logic [15:0] yv,
                           input logic [5:0] cv, input logic [15:0] eo, input logic ez, input logic en);
    out_ready = 1'b1; in_valid = 1'b1; x = xv; y = yv; ctrl = cv;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; x = 16'hDEAD; y = 16'hBEEF;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_latency1 got=%b exp=0", nm, out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got=%b exp=1", nm, out_valid); end
    n_cmp++; if (out_o !== eo) begin n_fail++; $display("FAIL %s_out got=%h exp=%h", nm, out_o, eo); end
    n_cmp++; if (zr !== ez || ng !== en) begin n_fail++; $display("FAIL %s_flags got zr=%b ng=%b exp zr=%b ng=%b", nm, zr, ng, ez, en); end
    @(posedge clk); #1;
    exp_ops = exp_ops + 16'd1;
    n_cmp++; if (ops_count !== exp_ops) begin n_fail++; $display("FAIL %s_ops got=%0d exp=%0d", nm, ops_count, exp_ops); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drained got=%b exp=0", nm, out_valid); end
  endtask

  task automatic test_and_path();
    single_op("and", 16'd10, 16'd7, 6'b000000, 16'd2, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    single_op("ovf", 16'hFFFF, 16'd1, 6'b000010, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] vx [4] = '{16'd15, 16'd1, 16'd9, 16'd0};
    logic [15:0] vy [4] = '{16'd2, 16'd2, 16'd9, 16'd0};
    logic [5:0]  vc [4] = '{6'b000010, 6'b010011, 6'b101010, 6'b111111};
    logic [15:0] eo [4] = '{16'd17, 16'hFFFF, 16'd0, 16'd1};
    logic        ez [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        en [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; x = vx[c]; y = vy[c]; ctrl = vc[c];
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", c-1, out_valid); end
        n_cmp++; if (out_o !== eo[c-1]) begin n_fail++; $display("FAIL b2b_out[%0d] got=%h exp=%h", c-1, out_o, eo[c-1]); end
        n_cmp++; if (zr !== ez[c-1] || ng !== en[c-1]) begin n_fail++; $display("FAIL b2b_flags[%0d] got zr=%b ng=%b exp zr=%b ng=%b", c-1, zr, ng, ez[c-1], en[c-1]); end
      end
    end
    exp_ops = exp_ops + 16'd4;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    n_cmp++; if (ops_count !== exp_ops) begin n_fail++; $display("FAIL b2b_ops got=%0d exp=%0d", ops_count, exp_ops); end
  endtask

  task automatic test_backpressure();
    logic [15:0] vx [3] = '{16'd3, 16'd12, 16'h8000};
    logic [15:0] vy [3] = '{16'd5, 16'd10, 16'd0};
    logic [5:0]  vc [3] = '{6'b000010, 6'b000001, 6'b000010};
    logic [15:0] eo [3] = '{16'd8, 16'hFFF7, 16'h8000};
    logic        en [3] = '{1'b0, 1'b1, 1'b1};
    int unsigned idx = 0;
    int unsigned got = 0;
    logic        held = 1'b0;
    logic [15:0] h_out;
    logic        h_zr, h_ng;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3); x = vx[idx < 3 ? idx : 2]; y = vy[idx < 3 ? idx : 2]; ctrl = vc[idx < 3 ? idx : 2];
      #1;
      n_cmp++; if (in_ready !== (c < 2)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", c, in_ready, (c < 2)); end
      if (in_ready && in_valid) idx++;
      @(posedge clk); #1;
      if (held) begin
        n_cmp++; if (out_o !== h_out || zr !== h_zr || ng !== h_ng)
          begin n_fail++; $display("FAIL bp_stable[%0d] got out=%h zr=%b ng=%b exp out=%h zr=%b ng=%b", c, out_o, zr, ng, h_out, h_zr, h_ng); end
      end else if (out_valid) begin
        held = 1'b1; h_out = out_o; h_zr = zr; h_ng = ng;
      end
    end
    n_cmp++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      in_valid = (idx < 3); x = vx[idx < 3 ? idx : 2]; y = vy[idx < 3 ? idx : 2]; ctrl = vc[idx < 3 ? idx : 2];
      #1;
      if (in_ready && in_valid) idx++;
      if (out_valid) begin
        n_cmp++; if (out_o !== eo[got] || ng !== en[got] || zr !== 1'b0)
          begin n_fail++; $display("FAIL bp_result[%0d] got out=%h zr=%b ng=%b exp out=%h zr=0 ng=%b", got, out_o, zr, ng, eo[got], en[got]); end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_ops = exp_ops + 16'd3;
    n_cmp++; if (got != 3) begin n_fail++; $display("FAIL bp_release_count got=%0d exp=3", got); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    n_cmp++; if (ops_count !== exp_ops) begin n_fail++; $display("FAIL bp_ops got=%0d exp=%0d", ops_count, exp_ops); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; x = 16'd2; y = 16'd3; ctrl = 6'b000010;
    @(posedge clk); #1;
    x = 16'd4; y = 16'd4; ctrl = 6'b000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    n_cmp++; if (ops_count !== 16'd0) begin n_fail++; $display("FAIL mid_ops got=%0d exp=0", ops_count); end
    n_cmp++; if (out_o !== 16'd0 || zr !== 1'b0 || ng !== 1'b0) begin n_fail++; $display("FAIL mid_out got out=%h zr=%b ng=%b exp 0000 0 0", out_o, zr, ng); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1; out_ready = 1'b1;
    exp_ops = 16'd0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d] got=%b exp=0", c, out_valid); end
    end
    single_op("post", 16'd6, 16'd3, 6'b000010, 16'd9, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_and_path();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_alu_pipe.md
# hack_alu_pipe

Two-stage pipelined, handshaked wrapper around the Hack ALU function. It is the stage directly downstream of the 16-bit bitwise AND block: the AND result is the ALU's `f=0` path. It accepts operand pairs plus the six Hack control bits, computes `out`, `zr` and `ng`, and presents the result under valid/ready flow control. It also counts completed operations. It sits between the CPU decode/operand-select logic and the D/A/M writeback path.

## Interface
- `N`, 16, operand and result width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous reset, active low, sampled on the `clk` rising edge.
- `in_valid` input 1: upstream offers `x`, `y`, `ctrl`.
- `in_ready` output 1: stage can accept this cycle.
- `x` input N: operand x.
- `y` input N: operand y.
- `ctrl` input 6: {zx, nx, zy, ny, f, no}; `ctrl[5]`=zx, `ctrl[0]`=no.
- `out_valid` output 1: result is present.
- `out_ready` input 1: downstream accepts the result.
- `out` output N: ALU result.
- `zr` output 1: `out` == 0.
- `ng` output 1: `out[N-1]`.
- `ops_count` output 16: number of completed output transfers, wraps modulo 2^16.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Stage 1 (preset) registers `x1` and `y1`, plus `f` and `no`:
  - `x1 = nx ? ~(zx ? 0 : x) : (zx ? 0 : x)`.
  - `y1` is formed the same way from `y` using zy and ny.
- Stage 2 (compute) registers `out`, `zr` and `ng`:
  - `r = f ? (x1 + y1) mod 2^N : (x1 & y1)`; the carry is discarded.
  - `out = no ? ~r : r`.
  - `zr = (out == 0)`, `ng = out[N-1]`; both are derived from the final `out`.
- Valid bits: `s1_valid` and `s2_valid`; `out_valid` = `s2_valid`.
- Advance rules:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = rst_n && s1_adv`; combinational from `out_ready`. This is the only combinational input-to-output path.
- On `s2_adv`: stage 2 loads from stage 1, and `s2_valid <= s1_valid`.
- On `s1_adv`: stage 1 loads the inputs, and `s1_valid <= in_valid`.
- Stalled registers hold their values. `out`, `zr` and `ng` must stay stable while `out_valid && !out_ready`.
- Ordering is strictly FIFO. No drop and no duplication.
- `ops_count` increments on each output transfer. Wrap: 0xFFFF -> 0x0000.
- When `out_valid` = 0, `out`, `zr` and `ng` hold their last value (0 after reset). Downstream must ignore them.

## Timing
- Reset (`rst_n` = 0 at an edge) clears the following after that edge:
  - `s1_valid` = 0, `s2_valid` = 0, `out_valid` = 0.
  - `out` = 0, `zr` = 0, `ng` = 0, `ops_count` = 0.
  - All stage-1 data registers = 0.
- `in_ready` = 0 while `rst_n` = 0.
- Reset mid-operation discards all in-flight data. No output transfer is counted on the reset edge.
- Latency is 2 cycles. An input accepted at edge k is presented with `out_valid` = 1 after edge k+1, i.e. it is transferable at edge k+2 when unstalled.
- Throughput is 1 operation per cycle with `out_ready` held high.
- Simultaneous output transfer and new input in the same cycle is legal with both stages full: the pipeline shifts and no bubble is inserted.
- Backpressure: with `out_ready` low, at most 2 operations are buffered. `in_ready` goes low in the same cycle that both stages are full and `out_ready` = 0.
- `in_valid` may drop without a transfer. Upstream data is only sampled on a transfer.

## Test plan
- Reset: hold `rst_n` low 3 cycles with `in_valid` = 1, `x` = 5.
  - Required: `in_ready` = 0, `out_valid` = 0, `out` = 0, `zr` = 0, `ng` = 0, `ops_count` = 0 throughout.
  - Required: the first `out_valid` appears no earlier than 2 edges after reset release plus an accepted input.
- AND path: `x` = 10, `y` = 7, `ctrl` = 000000, `out_ready` = 1.
  - Required: 2 edges later `out` = 2, `zr` = 0, `ng` = 0, `ops_count` = 1.
- Back-to-back, one per cycle with `out_ready` = 1:
  - (15, 2, 000010) -> 17.
  - (1, 2, 010011) -> 0xFFFF, `ng` = 1.
  - (9, 9, 101010) -> 0, `zr` = 1.
  - (0, 0, 111111) -> 1.
  - Required: results on 4 consecutive cycles, in order, `ops_count` = 4.
- Backpressure: `out_ready` = 0 for 5 cycles with 3 operations offered.
  - Required: exactly 2 accepted, then `in_ready` = 0.
  - Required: `out`, `zr` and `ng` stable throughout the stall.
  - Release: 3 results in order, with no loss and no duplicate.
- Overflow: `x` = 0xFFFF, `y` = 1, `ctrl` = 000010.
  - Required: `out` = 0, `zr` = 1, `ng` = 0.
- Reset mid-flight: 2 operations in the pipe, `rst_n` low for one edge.
  - Required: after that edge `out_valid` = 0 and `ops_count` = 0.
  - Required: no stale result ever appears after reset.
